// File: rtl/eva_axi_mem_slv.sv
// eva_axi_mem_slv: AXI4 slave memory model with queued reads, B channel and optional LFSR back-pressure
module eva_axi_mem_slv #(
  parameter int          DATA_W    = 128,
  parameter int          ADDR_W    = 32,
  parameter int          ID_W      = 4,
  parameter int          LEN_W     = 6,
  parameter int          MEM_AW    = 10,
  parameter int          RD_OUTST  = 4,
  parameter bit          STALL_EN  = 1'b0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                aclk,
  input  logic                arest_n,
  input  logic                arvalid,
  output logic                arready,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [LEN_W-1:0]    arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  output logic                rvalid,
  input  logic                rready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic                rlast,
  output logic [1:0]          rresp,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [LEN_W-1:0]    awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                wvalid,
  output logic                wready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  output logic                bvalid,
  input  logic                bready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp
);
  localparam int BYTES = DATA_W / 8;
  localparam int BL = $clog2(BYTES);
  localparam int PW = $clog2(RD_OUTST);
  localparam logic [2:0] SZ = 3'(BL);
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [0:0] R_IDLE = 1'b0, R_BURST = 1'b1;
  localparam logic [1:0] W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2;

  logic [DATA_W-1:0] mem [2**MEM_AW];
  logic [15:0] lfsr;
  logic stall, live;
  logic [ID_W-1:0] q_id [RD_OUTST];
  logic [MEM_AW-1:0] q_idx [RD_OUTST];
  logic [LEN_W-1:0] q_len [RD_OUTST];
  logic q_fix [RD_OUTST];
  logic q_err [RD_OUTST];
  logic [PW:0] wp, rp;
  logic [PW-1:0] rh;
  logic full, empty, push, pop;
  logic [0:0] r_st;
  logic [MEM_AW-1:0] r_idx, rd_idx;
  logic [LEN_W-1:0] r_cnt, r_len;
  logic r_fix, r_err, r_load;
  logic [1:0] w_st;
  logic [MEM_AW-1:0] w_idx;
  logic [LEN_W-1:0] w_cnt, w_len;
  logic w_fix, w_err, w_bad, w_fire;
  logic unused_bits;

  assign unused_bits = ^{araddr, awaddr};
  assign stall = STALL_EN & lfsr[0];
  assign rh = rp[PW-1:0];
  assign empty = wp == rp;
  assign full = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
  assign arready = live & !full & !stall;
  assign push = arvalid & arready;
  assign pop = (r_st == R_IDLE) & !empty & !stall;
  assign rd_idx = (r_st == R_IDLE) ? q_idx[rh] : r_fix ? r_idx : r_idx + 1'b1;
  assign r_load = (r_st == R_BURST) & (!rvalid | (rready & !rlast)) & !stall;
  assign awready = live & (w_st == W_IDLE) & !stall;
  assign wready = (w_st == W_DATA) & !stall;
  assign w_fire = wvalid & wready;

  // Back-pressure LFSR and a flag that holds the ready outputs low until reset has been released
  always_ff @(posedge aclk or negedge arest_n)
    if (!arest_n) begin
      lfsr <= LFSR_SEED;
      live <= 1'b0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      live <= 1'b1;
    end

  // Read-address queue storage: decoded beat index, burst kind and error flag per entry
  always_ff @(posedge aclk)
    if (push) begin
      q_id[wp[PW-1:0]] <= arid;
      q_idx[wp[PW-1:0]] <= araddr[MEM_AW+BL-1:BL];
      q_len[wp[PW-1:0]] <= arlen;
      q_fix[wp[PW-1:0]] <= arburst == 2'b00;
      q_err[wp[PW-1:0]] <= (arsize != SZ) | arburst[1];
    end

  // Read-address queue pointers; the extra msb separates full from empty
  always_ff @(posedge aclk or negedge arest_n)
    if (!arest_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + {{PW{1'b0}}, push};
      rp <= rp + {{PW{1'b0}}, pop};
    end

  // Read engine: pop a request, then present one beat at a time in the R output register
  always_ff @(posedge aclk or negedge arest_n)
    if (!arest_n) begin
      r_st <= R_IDLE;
      rvalid <= 1'b0;
      rid <= '0;
      rdata <= '0;
      rresp <= '0;
      rlast <= 1'b0;
      r_idx <= '0;
      r_cnt <= '0;
      r_len <= '0;
      r_fix <= 1'b0;
      r_err <= 1'b0;
    end else if (pop) begin
      r_st <= R_BURST;
      rvalid <= 1'b1;
      rid <= q_id[rh];
      rresp <= q_err[rh] ? SLVERR : 2'b00;
      rdata <= q_err[rh] ? '0 : mem[rd_idx];
      rlast <= q_len[rh] == '0;
      r_idx <= rd_idx;
      r_cnt <= '0;
      r_len <= q_len[rh];
      r_fix <= q_fix[rh];
      r_err <= q_err[rh];
    end else if (r_load) begin
      rvalid <= 1'b1;
      rdata <= r_err ? '0 : mem[rd_idx];
      r_idx <= rd_idx;
      r_cnt <= r_cnt + 1'b1;
      rlast <= r_cnt + 1'b1 == r_len;
    end else if (rvalid & rready) begin
      rvalid <= 1'b0;
      if (rlast) r_st <= R_IDLE;
    end

  // Write engine: accept one AW, count W beats to len, then hold the B response
  always_ff @(posedge aclk or negedge arest_n)
    if (!arest_n) begin
      w_st <= W_IDLE;
      bvalid <= 1'b0;
      bid <= '0;
      bresp <= '0;
      w_idx <= '0;
      w_cnt <= '0;
      w_len <= '0;
      w_fix <= 1'b0;
      w_err <= 1'b0;
      w_bad <= 1'b0;
    end else if (awvalid & awready) begin
      w_st <= W_DATA;
      bid <= awid;
      w_idx <= awaddr[MEM_AW+BL-1:BL];
      w_cnt <= '0;
      w_len <= awlen;
      w_fix <= awburst == 2'b00;
      w_err <= (awsize != SZ) | awburst[1];
      w_bad <= 1'b0;
    end else if (w_fire) begin
      w_cnt <= w_cnt + 1'b1;
      w_idx <= w_fix ? w_idx : w_idx + 1'b1;
      if (w_cnt == w_len) begin
        w_st <= W_RESP;
        bvalid <= 1'b1;
        bresp <= (w_err | w_bad | !wlast) ? SLVERR : 2'b00;
      end else w_bad <= w_bad | wlast;
    end else if (bvalid & bready) begin
      bvalid <= 1'b0;
      w_st <= W_IDLE;
    end

  // Byte-masked memory write; a read of the same entry on this edge still sees the old data
  always_ff @(posedge aclk)
    if (w_fire & !w_err)
      for (int i = 0; i < BYTES; i++)
        if (wstrb[i]) mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
endmodule
